// File: rtl/readout_shift_buffer.sv
// Parallel-load shift buffer: captures LENGTH words in one load and streams them
// out one word per valid/ready handshake, with count, done, load_err and flush.
module readout_shift_buffer #(
    parameter int              BITS      = 4,
    parameter int              LENGTH    = 4,
    parameter int              MSB_FIRST = 0,
    parameter logic [BITS-1:0] FILL      = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          flush,
    input  logic [BITS*LENGTH-1:0]        data_in,
    output logic [BITS-1:0]               out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(LENGTH+1)-1:0]   count,
    output logic                          done,
    output logic                          load_err
);

    localparam int COUNT_W = $clog2(LENGTH+1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [BITS-1:0]    slot_q [LENGTH];
    logic [BITS-1:0]    slot_d [LENGTH];
    logic               done_q, done_d;
    logic               load_err_q, load_err_d;

    // Slot 0 is always the head; load order is remapped so shifting is one-directional.
    logic [BITS-1:0]    load_word  [LENGTH];
    logic [BITS-1:0]    shift_word [LENGTH];

    genvar gi;
    generate
        for (gi = 0; gi < LENGTH; gi++) begin : g_slot
            if (MSB_FIRST != 0) begin : g_msb
                assign load_word[gi] = data_in[(LENGTH-1-gi)*BITS +: BITS];
            end else begin : g_lsb
                assign load_word[gi] = data_in[gi*BITS +: BITS];
            end

            if (gi == LENGTH-1) begin : g_tail
                assign shift_word[gi] = FILL;
            end else begin : g_body
                assign shift_word[gi] = slot_q[gi+1];
            end
        end
    endgenerate

    logic xfer;
    logic last_xfer;

    assign xfer      = (state_q == ST_SHIFT) && out_ready;
    assign last_xfer = xfer && (count_q == COUNT_W'(1));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        slot_d     = slot_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            count_d = '0;
            for (int i = 0; i < LENGTH; i++) begin
                slot_d[i] = FILL;
            end
        end else if (load && ((state_q == ST_IDLE) || last_xfer)) begin
            // A load coinciding with the final transfer refills without a bubble.
            state_d = ST_SHIFT;
            count_d = COUNT_W'(LENGTH);
            slot_d  = load_word;
            done_d  = last_xfer;
        end else begin
            if (xfer) begin
                slot_d  = shift_word;
                count_d = count_q - COUNT_W'(1);
                if (last_xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            if (load && (state_q == ST_SHIFT)) begin
                load_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                slot_q[i] <= FILL;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
            slot_q     <= slot_d;
        end
    end

    assign out_data  = slot_q[0];
    assign out_valid = (state_q == ST_SHIFT);
    assign count     = count_q;
    assign done      = done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_readout_shift_buffer.sv
// Scoreboard bench: two instances (LSB-first, FILL=0 and MSB-first, FILL=F) share
// stimulus; a negedge monitor pops expected words on every accepted handshake.
module tb_readout_shift_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        flush;
    logic [15:0] data_in;
    logic        out_ready;

    logic [3:0]  od0, od1;
    logic        v0, v1;
    logic [2:0]  cnt0, cnt1;
    logic        done0, done1;
    logic        lerr0, lerr1;

    int tests = 0;
    int fails = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] exp0, exp1;

    always #5 clk = ~clk;

    readout_shift_buffer #(.BITS(4), .LENGTH(4), .MSB_FIRST(0), .FILL(4'h0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .flush(flush), .data_in(data_in),
        .out_data(od0), .out_valid(v0), .out_ready(out_ready), .count(cnt0),
        .done(done0), .load_err(lerr0)
    );

    readout_shift_buffer #(.BITS(4), .LENGTH(4), .MSB_FIRST(1), .FILL(4'hF)) dut1 (
        .clk(clk), .reset(reset), .load(load), .flush(flush), .data_in(data_in),
        .out_data(od1), .out_valid(v1), .out_ready(out_ready), .count(cnt1),
        .done(done1), .load_err(lerr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input logic [15:0] d);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(d[i*4 +: 4]);
            q1.push_back(d[(3-i)*4 +: 4]);
        end
    endtask

    // Monitor: each accepted handshake pops one expected word per instance.
    always @(negedge clk) begin
        if (!reset && !flush) begin
            if (v0 && out_ready) begin
                tests++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL dut0_word: got %0h expected none", od0);
                end else begin
                    exp0 = q0.pop_front();
                    if (od0 !== exp0) begin
                        fails++;
                        $display("FAIL dut0_word: got %0h expected %0h", od0, exp0);
                    end else $display("[TB] dut0 word %0h", od0);
                end
            end
            if (v1 && out_ready) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL dut1_word: got %0h expected none", od1);
                end else begin
                    exp1 = q1.pop_front();
                    if (od1 !== exp1) begin
                        fails++;
                        $display("FAIL dut1_word: got %0h expected %0h", od1, exp1);
                    end else $display("[TB] dut1 word %0h", od1);
                end
            end
        end
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    initial begin
        int dc;
        logic [3:0] prev;
        logic rdy;

        reset = 1'b1; load = 1'b0; flush = 1'b0; out_ready = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", v0, 0);
        chk("rst_valid1", v1, 0);
        chk("rst_count0", cnt0, 0);
        chk("rst_data0", od0, 4'h0);
        chk("rst_data1", od1, 4'hF);
        chk("rst_done0", done0, 0);
        chk("rst_lerr0", lerr0, 0);
        reset = 1'b0;
        tick();

        // 1/2: straight burst, both directions
        data_in = 16'hDCBA; load = 1'b1; out_ready = 1'b1; push_load(16'hDCBA);
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_count", cnt0, 4 - k);
            chk("t1_valid", v0, 1);
            tick();
        end
        chk("t1_count_end", cnt0, 0);
        chk("t1_valid_end", v0, 0);
        chk("t1_done0", done0, 1);
        chk("t1_done1", done1, 1);
        tick();
        chk("t1_done_clr", done0, 0);
        chk("t2_fill0", od0, 4'h0);
        chk("t2_fill1", od1, 4'hF);

        // 3: backpressure 1,0,0,1,...
        data_in = 16'h5A3C; load = 1'b1; out_ready = 1'b0; push_load(16'h5A3C);
        tick();
        load = 1'b0;
        for (int i = 0; i < 30 && cnt0 != 0; i++) begin
            rdy = (i % 3 == 0);
            out_ready = rdy;
            prev = od0;
            tick();
            if (!rdy) chk("t3_stall_hold", od0, prev);
            if (cnt0 != 0) chk("t3_no_early_done", done0, 0);
        end
        chk("t3_drained", cnt0, 0);
        chk("t3_done", done0, 1);
        tick();

        // 4: back-to-back load, then rejected load
        data_in = 16'hDCBA; load = 1'b1; out_ready = 1'b1; push_load(16'hDCBA);
        tick();
        load = 1'b0;
        repeat (3) tick();
        chk("t4_count1", cnt0, 1);
        dc = done_cnt0;
        data_in = 16'h4321; load = 1'b1; push_load(16'h4321);
        tick();
        load = 1'b0;
        chk("t4_b2b_count", cnt0, 4);
        chk("t4_b2b_valid", v0, 1);
        chk("t4_b2b_done", done0, 1);
        tick();
        chk("t4_count3", cnt0, 3);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("t4_lerr0", lerr0, 1);
        chk("t4_lerr1", lerr1, 1);
        chk("t4_rej_count", cnt0, 2);
        tick();
        chk("t4_lerr_clr", lerr0, 0);
        chk("t4_count1b", cnt0, 1);
        tick();
        chk("t4_count0", cnt0, 0);
        chk("t4_done2", done0, 1);
        tick();
        chk("t4_done_pulses", done_cnt0 - dc, 2);

        // 5: flush with concurrent load and ready
        data_in = 16'h8765; load = 1'b1; out_ready = 1'b1; push_load(16'h8765);
        tick();
        load = 1'b0;
        repeat (2) tick();
        chk("t5_count2", cnt0, 2);
        dc = done_cnt0;
        flush = 1'b1; load = 1'b1;
        tick();
        flush = 1'b0; load = 1'b0;
        q0.delete(); q1.delete();
        chk("t5_count", cnt0, 0);
        chk("t5_valid", v0, 0);
        chk("t5_lerr", lerr0, 0);
        chk("t5_done", done0, 0);
        tick();
        chk("t5_done_late", done0, 0);
        chk("t5_fill0", od0, 4'h0);
        chk("t5_fill1", od1, 4'hF);
        chk("t5_no_done", done_cnt0 - dc, 0);

        // 6: async reset mid-burst
        data_in = 16'h2468; load = 1'b1; out_ready = 1'b1; push_load(16'h2468);
        tick();
        load = 1'b0;
        tick();
        chk("t6_count3", cnt0, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", v0, 0);
        chk("t6_count", cnt0, 0);
        chk("t6_data0", od0, 4'h0);
        chk("t6_data1", od1, 4'hF);
        q0.delete(); q1.delete();
        dc = done_cnt0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (3) tick();
        chk("t6_no_done", done_cnt0 - dc, 0);
        chk("t6_idle", v0, 0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
